// File: rtl/inc_arb_pkg.sv
// Package for the shared increment arbiter.
// Provides the output-register state encoding and the default sizing
// constants used by inc_share_arbiter and rr_pick.
package inc_arb_pkg;

  // Output register occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_WIDTH = 4;

endpackage : inc_arb_pkg

// File: rtl/inc_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Searches req starting at (last_grant+1) mod NREQ, wrapping upward, and
// returns the first set bit.
// Ports:
//   req        - request vector, one bit per requester
//   last_grant - index of the most recently granted requester
//   gnt_oh     - one-hot grant (all zero when no request)
//   gnt_idx    - binary index of the granted requester
//   any        - at least one request is present
module rr_pick
  import inc_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  always_comb begin
    int unsigned idx;
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    // Offsets 1..NREQ visit last_grant+1 first and last_grant itself last.
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!any && req[idx]) begin
        any         = 1'b1;
        gnt_idx     = IDW'(idx);
        gnt_oh[idx] = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/inc_share_arbiter.sv
// inc_share_arbiter: shares one WIDTH-bit increment datapath between NREQ
// requesters. One operand is taken per cycle in round-robin order, incremented
// with carry-out, and held tagged with its requester id in a single output
// register until the consumer accepts it.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req_valid   - per-requester operand valid
//   req_data    - packed operands, requester i in [i*WIDTH +: WIDTH]
//   req_ready   - per-requester take strobe (at most one bit set)
//   rsp_valid   - result register occupied
//   rsp_data    - operand+1 modulo 2^WIDTH
//   rsp_carry   - carry-out of the increment
//   rsp_id      - index of the requester that produced the result
//   rsp_ready   - consumer accepts the result this cycle
module inc_share_arbiter
  import inc_arb_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_carry,
  output logic [IDW-1:0]        rsp_id,
  input  logic                  rsp_ready
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   last_q, last_d;

  logic [NREQ-1:0]  gnt_oh;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic             can_accept;
  logic             take;
  logic [WIDTH-1:0] operand;
  logic [WIDTH:0]   sum;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_q),
    .gnt_oh     (gnt_oh),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // The register frees up either when empty or when its result retires on
  // this same edge, which gives one result per cycle under rsp_ready=1.
  assign can_accept = (state_q == EMPTY) || ((state_q == FULL) && rsp_ready);

  // rst_n gating keeps req_ready low throughout reset even though the
  // reset state (EMPTY) would otherwise allow a grant.
  assign take      = rst_n && can_accept && gnt_any;
  assign req_ready = take ? gnt_oh : '0;

  // Operand mux driven by the one-hot grant, so req_data never feeds req_ready.
  always_comb begin
    operand = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        operand = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sum = {1'b0, operand} + (WIDTH+1)'(1);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    carry_d = carry_q;
    id_d    = id_q;
    last_d  = last_q;
    if (take) begin
      state_d = FULL;
      data_d  = sum[WIDTH-1:0];
      carry_d = sum[WIDTH];
      id_d    = gnt_idx;
      last_d  = gnt_idx;
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // Priority restarts at requester 0 by parking last_grant on NREQ-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
      last_q  <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = data_q;
  assign rsp_carry = carry_q;
  assign rsp_id    = id_q;

endmodule : inc_share_arbiter

// File: doc/inc_share_arbiter.md
# inc_share_arbiter

Shares one WIDTH-bit increment datapath between NREQ requesters. Each requester offers an operand with a valid/ready handshake; the block picks one per cycle round-robin, computes operand+1 with carry-out, and holds the tagged result in a single output register until the consumer accepts it. It sits between the requester-side control logic and the shared adder/subtractor resources, as the scheduler for the increment path.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, operand/result width.
- IDW, $clog2(NREQ), width of the requester id.

Ports:
- clk, input, 1, the single clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, NREQ, bit i: requester i presents an operand.
- req_data, input, NREQ*WIDTH, operand of requester i in bits [i*WIDTH +: WIDTH].
- req_ready, output, NREQ, bit i: requester i's operand is taken this cycle (at most one bit set).
- rsp_valid, output, 1, the result register holds a result.
- rsp_data, output, WIDTH, operand+1, modulo 2^WIDTH.
- rsp_carry, output, 1, carry-out of the increment (1 only when operand was all ones).
- rsp_id, output, IDW, index of the requester that produced the result.
- rsp_ready, input, 1, the consumer accepts the result this cycle.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Output register states (package enum): EMPTY, FULL.
- can_accept = (state==EMPTY) | (rsp_ready & state==FULL).
- Grant: when can_accept and any req_valid, grant the first valid requester found by searching from index (last_grant+1) mod NREQ upward with wrap. req_ready = one-hot(grant) gated by can_accept; req_ready=0 otherwise. req_ready depends combinationally on req_valid, state and rsp_ready only, never on req_data.
- On a granted transfer: rsp_data <= operand+1 (low WIDTH bits), rsp_carry <= bit WIDTH of the (WIDTH+1)-bit sum, rsp_id <= grant index, last_grant <= grant index, state -> FULL.
- FULL with rsp_ready=1 and no grant -> EMPTY. FULL with rsp_ready=0 -> hold; all rsp_* stable, req_ready=0.
- Simultaneous rsp_ready and new grant in FULL: the old result retires and the new one loads in the same edge; state stays FULL. This gives back-to-back throughput.
- last_grant changes only on a granted transfer. An idle cycle does not advance the priority.
- A requester may drop req_valid without a grant; no state change results.

## Timing
- Reset values: state=EMPTY, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_id=0, last_grant=NREQ-1 (so requester 0 has first priority), req_ready=0 while rst_n=0.
- Latency: a grant at edge N gives rsp_valid=1 with that result after edge N (visible in cycle N+1).
- Throughput: one result per cycle while rsp_ready=1 and requests are pending.
- Fairness: with all NREQ requesters continuously valid and rsp_ready=1, grants cycle 0,1,..,NREQ-1,0,...; no requester waits more than NREQ-1 grants.
- Reset mid-operation: asserting rst_n low immediately (asynchronously) clears rsp_valid and state. A pending result is discarded, not delivered. After deassertion, priority restarts at requester 0.

## Structure
- Package inc_arb_pkg: state enum {EMPTY, FULL}; default NREQ/WIDTH constants.
- One sub-module, rr_pick: combinational round-robin picker (inputs req vector and last_grant; outputs one-hot grant, index and any). The top holds the state, output register and increment.

## Test plan
- Reset then single request: req_valid=0001, req_data[0]=4'h5, rsp_ready=1 -> req_ready=0001 in that cycle; next cycle rsp_valid=1, rsp_data=4'h6, rsp_carry=0, rsp_id=0.
- Wrap-around: requester 2 sends 4'hF -> rsp_data=4'h0, rsp_carry=1, rsp_id=2.
- Round-robin: all four valid (data 1,2,3,4), rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3 with rsp_data 2,3,4,5 repeating; one result per cycle.
- Backpressure: load a result with rsp_ready=0 for 3 cycles and requests pending -> req_ready=0, rsp_* stable throughout; raising rsp_ready retires it and grants the next requester in the same cycle.
- Priority memory: grant 1, idle 2 cycles, then requesters 0 and 1 both valid -> requester 0 granted first (search starts at 2 and wraps), then 1.
- Async reset while FULL: rst_n low mid-cycle -> rsp_valid drops to 0 before the next edge; after release, all valid -> first grant is requester 0.
